// File: rtl/reset_release_sequencer_pkg.sv
// reset_sequencer_pkg: shared FSM states, counter sizing and stage-index width for the reset sequencer
package reset_sequencer_pkg;
  typedef enum logic [1:0] {HOLD, DELAY, WAIT, RUN} seq_state_e;
  localparam int STAGE_IDX_W = 4;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/reset_release_sequencer_if.sv
// reset_release_sequencer_if: per-domain reset/ack bundle plus clock enable and status
interface reset_release_sequencer_if #(
  parameter int Stage_Count = 4
);
  logic [Stage_Count-1:0] stage_ready;
  logic [Stage_Count-1:0] sync_rst;
  logic [Stage_Count-1:0] timeout_fault;
  logic                   clk_en;
  logic                   sequence_done;
  modport master (input stage_ready, output sync_rst, timeout_fault, clk_en, sequence_done);
  modport slave  (output stage_ready, input sync_rst, timeout_fault, clk_en, sequence_done);
endinterface

// File: rtl/reset_release_sequencer_sync.sv
// reset_synchronizer: async-assert / sync-deassert reset chain
module reset_synchronizer #(
  parameter int Stages = 2
) (
  input  logic clk,
  input  logic rst_i,
  output logic rst_o
);
  logic [Stages-1:0] chain_q;
  // shift zeros in once the asynchronous reset is gone
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) chain_q <= '1;
    else chain_q <= {chain_q[Stages-2:0], 1'b0};
  assign rst_o = chain_q[Stages-1];
endmodule

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: releases downstream reset domains in order, then starts the clock enable
module reset_release_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int Stage_Count          = 4,
  parameter int Sync_Stages          = 2,
  parameter int Stage_Delay_Cycles   = 8,
  parameter int Ready_Timeout_Cycles = 64,
  parameter int Clk_En_Divide        = 1
) (
  input logic clk,
  input logic async_rst,
  reset_release_sequencer_if.master bus
);
  localparam int CW = cnt_width(Stage_Delay_Cycles, Ready_Timeout_Cycles, Clk_En_Divide);
  localparam logic [CW-1:0] DLY_LAST = CW'(Stage_Delay_Cycles - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(Ready_Timeout_Cycles - 1);
  localparam logic [CW-1:0] EN_LAST  = CW'(Clk_En_Divide - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [STAGE_IDX_W-1:0] IDX_LAST = STAGE_IDX_W'(Stage_Count - 1);

  seq_state_e             state_q, state_d;
  logic [STAGE_IDX_W-1:0] idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [Stage_Count-1:0] sync_rst_q, sync_rst_d, fault_q, fault_d, sel;
  logic                   clk_en_q, clk_en_d, done_q, done_d;
  logic                   rst_sync, ready, rel, adv, to, last;

  reset_synchronizer #(.Stages(Sync_Stages)) u_sync (
    .clk  (clk),
    .rst_i(async_rst),
    .rst_o(rst_sync)
  );

  // The synchronizer output is seen one edge after it drops, so HOLD hands DELAY a pre-counted
  // cycle; with a single-cycle delay stage 0 is released straight from HOLD.
  assign sel     = Stage_Count'(1) << idx_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign ready   = |(bus.stage_ready & sel);
  assign last    = idx_q == IDX_LAST;
  assign rel     = (state_q == DELAY && cnt_q == DLY_LAST) ||
                   (state_q == HOLD && !rst_sync && Stage_Delay_Cycles == 1);
  assign to      = state_q == WAIT && !ready && cnt_q == TO_LAST;
  assign adv     = state_q == WAIT && (ready || cnt_q == TO_LAST);

  // next-state: count delays/timeouts, release the current stage, advance on ack or timeout
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_inc;
    sync_rst_d = sync_rst_q;
    fault_d    = fault_q;
    clk_en_d   = clk_en_q;
    done_d     = done_q;
    case (state_q)
      HOLD: begin
        state_d = rst_sync ? HOLD : DELAY;
        cnt_d   = rst_sync ? '0 : CW'(1);
      end
      RUN: begin
        cnt_d    = (cnt_q == EN_LAST) ? '0 : cnt_inc;
        clk_en_d = cnt_q == EN_LAST;
      end
      default: ;
    endcase
    if (rel) begin
      state_d    = WAIT;
      cnt_d      = '0;
      sync_rst_d = sync_rst_q & ~sel;
    end
    if (adv) begin
      state_d  = last ? RUN : DELAY;
      idx_d    = last ? idx_q : idx_q + 1'b1;
      cnt_d    = '0;
      fault_d  = fault_q | (to ? sel : '0);
      done_d   = last;
      clk_en_d = last;
    end
  end

  // state and registered outputs, all cleared immediately by the incoming reset
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) begin
      state_q    <= HOLD;
      idx_q      <= '0;
      cnt_q      <= '0;
      sync_rst_q <= '1;
      fault_q    <= '0;
      clk_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sync_rst_q <= sync_rst_d;
      fault_q    <= fault_d;
      clk_en_q   <= clk_en_d;
      done_q     <= done_d;
    end

  assign bus.sync_rst      = sync_rst_q;
  assign bus.timeout_fault = fault_q;
  assign bus.clk_en        = clk_en_q;
  assign bus.sequence_done = done_q;
endmodule
